// File: rtl/udp_tx_arbiter.sv
// Packet-level round-robin arbiter for the UDP egress path.
// Holds a grant per packet, registers the output and truncates overlong packets.
module udp_tx_arbiter #(
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int N_PORTS = 2,
  parameter int MAX_BEATS = 256
) (
  input  logic                                    core_clk,
  input  logic                                    core_rst_n,
  input  logic [N_PORTS*C_S_AXI_DATA_WIDTH-1:0]   in_tdata,
  input  logic [N_PORTS*C_S_AXI_DATA_WIDTH/8-1:0] in_tkeep,
  input  logic [N_PORTS-1:0]                      in_tvalid,
  input  logic [N_PORTS-1:0]                      in_tlast,
  output logic [N_PORTS-1:0]                      in_tready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]           out_tdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]         out_tkeep,
  output logic                                    out_tvalid,
  output logic                                    out_tlast,
  input  logic                                    out_tready,
  output logic [1:0]                              grant_id,
  output logic                                    busy,
  output logic                                    pkt_trunc
);

  localparam int W  = C_S_AXI_DATA_WIDTH;
  localparam int KW = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]    last_grant;
  logic [1:0]    sel;
  logic          sel_vld;
  logic [15:0]   beat_cnt;
  logic          g_valid;
  logic          g_last;
  logic          g_ready;
  logic [W-1:0]  g_data;
  logic [KW-1:0] g_keep;
  logic          acc;
  logic          cnt_hit;

  // Walk from lowest to highest priority so the nearest port wins.
  always_comb begin
    sel     = last_grant;
    sel_vld = 1'b0;
    for (int k = N_PORTS; k >= 1; k--) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (p == (int'(last_grant) + k) % N_PORTS && in_tvalid[p]) begin
          sel     = 2'(p);
          sel_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    g_keep  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (grant_id == 2'(p)) begin
        g_valid = in_tvalid[p];
        g_last  = in_tlast[p];
        g_data  = in_tdata[p*W +: W];
        g_keep  = in_tkeep[p*KW +: KW];
      end
    end
  end

  assign acc     = g_valid & g_ready;
  assign cnt_hit = ({1'b0, beat_cnt} + 17'd1) == 17'(MAX_BEATS);

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (sel_vld) state_nxt = BUSY;
      end
      BUSY: begin
        if (acc && g_last)       state_nxt = IDLE;
        else if (acc && cnt_hit) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (acc && g_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    g_ready   = 1'b0;
    in_tready = '0;
    busy      = 1'b0;
    unique case (state)
      BUSY: begin
        g_ready = ~out_tvalid | out_tready;
        busy    = 1'b1;
      end
      DRAIN: begin
        g_ready = 1'b1;
        busy    = 1'b1;
      end
      default: begin
        g_ready = 1'b0;
      end
    endcase
    for (int p = 0; p < N_PORTS; p++) begin
      in_tready[p] = g_ready & (grant_id == 2'(p));
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      last_grant <= 2'(N_PORTS - 1);
      grant_id   <= 2'd0;
      beat_cnt   <= '0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      pkt_trunc  <= 1'b0;
    end else begin
      pkt_trunc <= 1'b0;
      if (state == IDLE && sel_vld) begin
        grant_id <= sel;
        beat_cnt <= '0;
      end
      if (acc) beat_cnt <= beat_cnt + 16'd1;
      if (acc && g_last) last_grant <= grant_id;
      if (state == BUSY && acc) begin
        out_tdata  <= g_data;
        out_tkeep  <= g_keep;
        out_tlast  <= g_last | cnt_hit;
        out_tvalid <= 1'b1;
        pkt_trunc  <= ~g_last & cnt_hit;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: directed scenarios plus random traffic
// checked against a packet-level reference model.
module tb_udp_tx_arbiter;

  localparam int W    = 64;
  localparam int KW   = W / 8;
  localparam int NP   = 3;
  localparam int MAXB = 4;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic               core_clk = 1'b0;
  logic               core_rst_n;
  logic [NP*W-1:0]    in_tdata;
  logic [NP*KW-1:0]   in_tkeep;
  logic [NP-1:0]      in_tvalid;
  logic [NP-1:0]      in_tlast;
  logic [NP-1:0]      in_tready;
  logic [W-1:0]       out_tdata;
  logic [KW-1:0]      out_tkeep;
  logic               out_tvalid;
  logic               out_tlast;
  logic               out_tready;
  logic [1:0]         grant_id;
  logic               busy;
  logic               pkt_trunc;

  udp_tx_arbiter #(
    .C_S_AXI_DATA_WIDTH(W),
    .N_PORTS(NP),
    .MAX_BEATS(MAXB)
  ) dut (
    .core_clk(core_clk),
    .core_rst_n(core_rst_n),
    .in_tdata(in_tdata),
    .in_tkeep(in_tkeep),
    .in_tvalid(in_tvalid),
    .in_tlast(in_tlast),
    .in_tready(in_tready),
    .out_tdata(out_tdata),
    .out_tkeep(out_tkeep),
    .out_tvalid(out_tvalid),
    .out_tlast(out_tlast),
    .out_tready(out_tready),
    .grant_id(grant_id),
    .busy(busy),
    .pkt_trunc(pkt_trunc)
  );

  always #5 core_clk = ~core_clk;

  int    n_chk = 0;
  int    n_fail = 0;
  beat_t srcq [NP][$];
  beat_t expq [$];
  logic [NP-1:0] pop;
  bit    m_busy;
  int    m_port;
  int    m_cnt;
  int    m_last;
  bit    trunc_pend;
  int    delivered;
  int    n_trunc;
  int    tr_mode;
  bit    gaps;
  int    cyc;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) srcq[p].delete();
    expq.delete();
    m_busy     = 1'b0;
    m_port     = 0;
    m_cnt      = 0;
    m_last     = NP - 1;
    trunc_pend = 1'b0;
    pop        = '0;
  endtask

  task automatic drive();
    logic [3:0] pat;
    pat = 4'b1001;
    for (int p = 0; p < NP; p++) begin
      if (pop[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
    end
    for (int p = 0; p < NP; p++) begin
      if (srcq[p].size() > 0) begin
        in_tvalid[p]          = !gaps || ($urandom_range(0, 3) != 0);
        in_tdata[p*W +: W]    = srcq[p][0].d;
        in_tkeep[p*KW +: KW]  = srcq[p][0].k;
        in_tlast[p]           = srcq[p][0].l;
      end else begin
        in_tvalid[p]          = 1'b0;
        in_tdata[p*W +: W]    = '0;
        in_tkeep[p*KW +: KW]  = '0;
        in_tlast[p]           = 1'b0;
      end
    end
    case (tr_mode)
      1:       out_tready = pat[cyc % 4];
      2:       out_tready = ($urandom_range(0, 2) != 0);
      default: out_tready = 1'b1;
    endcase
    cyc++;
    pop = '0;
  endtask

  // One clock: check DUT against the model before the edge, then advance.
  task automatic step();
    logic [NP-1:0] er;
    bit ofree;
    bit lst;
    bit found;
    int idx;
    @(negedge core_clk);
    chk("out_tvalid", out_tvalid, 64'(expq.size() > 0));
    if (expq.size() > 0) begin
      chk("out_tdata", out_tdata, expq[0].d);
      chk("out_tkeep", out_tkeep, 64'(expq[0].k));
      chk("out_tlast", out_tlast, 64'(expq[0].l));
    end
    chk("pkt_trunc", pkt_trunc, 64'(trunc_pend));
    if (pkt_trunc === 1'b1) n_trunc++;
    chk("busy", busy, 64'(m_busy));
    if (m_busy) chk("grant_id", grant_id, 64'(m_port));
    ofree = (expq.size() == 0) || out_tready;
    er = '0;
    if (m_busy) er[m_port] = (m_cnt >= MAXB) ? 1'b1 : ofree;
    chk("in_tready", in_tready, 64'(er));
    pop = in_tvalid & er;
    if (expq.size() > 0 && out_tready) begin
      void'(expq.pop_front());
      delivered++;
    end
    trunc_pend = 1'b0;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        idx = (m_last + k) % NP;
        if (!found && in_tvalid[idx]) begin
          found  = 1'b1;
          m_port = idx;
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end
    end else if (pop[m_port]) begin
      lst = in_tlast[m_port];
      if (m_cnt < MAXB) begin
        expq.push_back('{d: in_tdata[m_port*W +: W],
                         k: in_tkeep[m_port*KW +: KW],
                         l: lst || (m_cnt + 1 == MAXB)});
        if (!lst && m_cnt + 1 == MAXB) trunc_pend = 1'b1;
      end
      m_cnt++;
      if (lst) begin
        m_busy = 1'b0;
        m_last = m_port;
      end
    end
    @(posedge core_clk);
    #1;
    drive();
  endtask

  task automatic push_pkt(int p, int len, logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      srcq[p].push_back('{d: {$urandom, $urandom} ^ 64'(base + 8'(i)),
                          k: 8'($urandom), l: (i == len - 1)});
    end
  endtask

  function automatic bit all_idle();
    bit e;
    e = !m_busy && expq.size() == 0;
    for (int p = 0; p < NP; p++) if (srcq[p].size() > 0) e = 1'b0;
    return e;
  endfunction

  initial begin
    int d0;
    core_rst_n = 1'b0;
    in_tdata   = '0;
    in_tkeep   = '0;
    in_tvalid  = '0;
    in_tlast   = '0;
    out_tready = 1'b1;
    tr_mode    = 0;
    gaps       = 1'b0;
    cyc        = 0;
    delivered  = 0;
    n_trunc    = 0;
    model_reset();
    repeat (3) @(posedge core_clk);
    #1;
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_out_tlast", out_tlast, 0);
    chk("rst_out_tdata", out_tdata, 0);
    chk("rst_out_tkeep", out_tkeep, 0);
    chk("rst_in_tready", in_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_pkt_trunc", pkt_trunc, 0);
    core_rst_n = 1'b1;

    // single 3-beat packet on port 0
    d0 = delivered;
    srcq[0].push_back('{d: 64'h11, k: 8'hFF, l: 1'b0});
    srcq[0].push_back('{d: 64'h22, k: 8'hFF, l: 1'b0});
    srcq[0].push_back('{d: 64'h33, k: 8'h0F, l: 1'b1});
    drive();
    repeat (8) step();
    chk("single_beats", 64'(delivered - d0), 3);

    // two requesters competing continuously
    d0 = delivered;
    push_pkt(0, 2, 8'h40);
    push_pkt(0, 2, 8'h50);
    push_pkt(1, 2, 8'h60);
    push_pkt(1, 2, 8'h70);
    drive();
    repeat (16) step();
    chk("fair_beats", 64'(delivered - d0), 8);

    // downstream stalls 1,0,0,1 during a 4-beat packet
    d0 = delivered;
    tr_mode = 1;
    push_pkt(2, 4, 8'h80);
    drive();
    repeat (20) step();
    chk("bp_beats", 64'(delivered - d0), 4);

    // 6-beat packet truncated at four beats
    d0 = delivered;
    n_trunc = 0;
    tr_mode = 0;
    push_pkt(1, 6, 8'h90);
    drive();
    repeat (12) step();
    chk("trunc_beats", 64'(delivered - d0), 4);
    chk("trunc_pulses", 64'(n_trunc), 1);
    chk("trunc_src_done", 64'(srcq[1].size()), 0);

    // reset lands in the middle of a 5-beat packet
    d0 = delivered;
    push_pkt(0, 5, 8'hA0);
    drive();
    for (int i = 0; i < 20 && delivered - d0 < 2; i++) step();
    chk("mid_rst_progress", 64'(delivered - d0), 2);
    core_rst_n = 1'b0;
    #1;
    chk("mid_rst_out_tvalid", out_tvalid, 0);
    chk("mid_rst_in_tready", in_tready, 0);
    chk("mid_rst_busy", busy, 0);
    model_reset();
    drive();
    @(posedge core_clk);
    #1;
    core_rst_n = 1'b1;
    push_pkt(1, 2, 8'hB0);
    push_pkt(0, 2, 8'hC0);
    drive();
    step();
    step();
    chk("post_rst_grant", grant_id, 0);
    repeat (10) step();

    // random traffic with source gaps and random backpressure
    tr_mode = 2;
    gaps    = 1'b1;
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (srcq[p].size() < 4 && $urandom_range(0, 7) == 0)
          push_pkt(p, $urandom_range(1, 6), 8'(i));
      end
      step();
    end
    tr_mode = 0;
    gaps    = 1'b0;
    for (int i = 0; i < 300 && !all_idle(); i++) step();
    chk("drain_done", 64'(all_idle()), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
# udp_tx_arbiter

Packet-level round-robin arbiter that shares one AXI4-Stream UDP transmit path between up to four requester streams, e.g. data, ACK/NAK and keep-alive generators. It sits in front of the keep-handling stage on the UDP egress path. A grant is held for a whole packet, so packets never interleave. The output is registered, and any packet longer than a configured limit is truncated and drained.

## Interface
- C_S_AXI_DATA_WIDTH, 64, data width per stream; multiple of 8.
- N_PORTS, 2, number of requesters; legal range 2..4.
- MAX_BEATS, 256, maximum beats per packet; legal range 2..65535.
- core_clk  in  1  sole clock; all logic is on the rising edge.
- core_rst_n  in  1  asynchronous, active-low reset.
- in_tdata  in  N_PORTS*C_S_AXI_DATA_WIDTH  port i occupies bits [i*W +: W].
- in_tkeep  in  N_PORTS*C_S_AXI_DATA_WIDTH/8  port i occupies bits [i*W/8 +: W/8].
- in_tvalid  in  N_PORTS  one valid bit per port.
- in_tlast  in  N_PORTS  one last bit per port.
- in_tready  out  N_PORTS  one ready bit per port.
- out_tdata  out  C_S_AXI_DATA_WIDTH  registered data.
- out_tkeep  out  C_S_AXI_DATA_WIDTH/8  registered keep.
- out_tvalid  out  1  registered valid.
- out_tlast  out  1  registered last.
- out_tready  in  1  downstream ready.
- grant_id  out  2  index of the current or most recent grant.
- busy  out  1  high while a grant is held (states BUSY and DRAIN).
- pkt_trunc  out  1  one-cycle pulse when a packet is truncated at MAX_BEATS.

## Operation
- State machine has three states: IDLE, BUSY, DRAIN.
- IDLE:
  - All in_tready are 0.
  - If any in_tvalid is 1, select the first valid port searching from (last_grant+1) mod N_PORTS upward with wrap.
  - Register the selection into grant_id, clear beat_cnt, go to BUSY.
  - Port bits at or above N_PORTS are ignored.
- BUSY:
  - in_tready[grant_id] = ~out_tvalid | out_tready. All other in_tready are 0.
  - An accepted beat loads the output register with the granted port's data, keep and last, sets out_tvalid, and increments beat_cnt.
  - If the accepted beat has tlast=1, set last_grant=grant_id and go to IDLE.
  - Else, if beat_cnt+1 == MAX_BEATS, force out_tlast=1 on that beat, pulse pkt_trunc, and go to DRAIN.
- DRAIN:
  - in_tready[grant_id] = 1. Beats are discarded and the output register is not loaded.
  - On an accepted tlast, set last_grant=grant_id and go to IDLE.
- Output register:
  - Clears out_tvalid when out_tready=1 and no new beat is loaded in the same cycle.
  - Holds all out_* stable while out_tvalid=1 and out_tready=0.
- beat_cnt is 16 bits and counts accepted beats of the current packet only.
- A source that drops tvalid mid-packet keeps the grant. The arbiter waits indefinitely; there is no timeout.
- No combinational path from in_tvalid/in_tdata to out_*. The only combinational input-to-output path is out_tready -> in_tready.

## Timing
- Reset values:
  - state=IDLE, last_grant=N_PORTS-1 (port 0 has first priority), grant_id=0.
  - out_tvalid=0, out_tlast=0, out_tdata=0, out_tkeep=0.
  - in_tready=0, busy=0, pkt_trunc=0.
- Reset is asynchronous and may arrive mid-packet. The partial packet is abandoned: out_tvalid drops immediately and no tlast is emitted.
- Arbitration costs one bubble cycle per packet. Request seen in IDLE at cycle t gives in_tready high at t+1; the first beat appears on out_* at t+2.
- Throughput: 1 beat/cycle within a packet when out_tready=1 continuously.
- Back-to-back packets from the same or different ports are separated by one IDLE cycle.
- A single-beat packet holds the grant for one beat only.
- pkt_trunc is high in the cycle after the truncating beat is accepted, coincident with that beat on out_*.
- Simultaneous requests are resolved strictly by round-robin order. A port that has just been served has lowest priority for the next packet.

## Test plan
- Single source: port 0 sends a 3-beat packet (data 0x11,0x22,0x33; keep 0xFF,0xFF,0x0F; last on beat 3), out_tready=1 -> three out beats at t+2..t+4, out_tlast only on 0x33, then busy falls.
- Fairness: ports 0 and 1 both continuously offer 2-beat packets -> output order is 0,1,0,1 with one idle cycle between packets and no interleaving within any packet.
- Backpressure: out_tready toggles 1,0,0,1 during a 4-beat packet -> out_* held stable while stalled, in_tready low whenever out_tvalid=1 and out_tready=0, all beats delivered in order with none lost or duplicated.
- Truncation: MAX_BEATS=4, port 1 sends 6 beats -> 4 output beats, the 4th with out_tlast=1, pkt_trunc pulses once, beats 5-6 accepted and discarded, then return to IDLE.
- Mid-packet reset: core_rst_n asserted after beat 2 of 5 -> out_tvalid=0 immediately. After release, port 0 wins the first arbitration.
